// File: rtl/mdu_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: operation codes and FSM states.
package mdu_pkg;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate.
// Used both to take operand magnitudes and to restore result signs.
module mdu_negate #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO.
// Uses shift-add multiply and restoring divide on operand magnitudes, with a final sign fix-up.
//
// state | meaning
// IDLE  | waiting for start; latches op, magnitudes and result signs
// CALC  | one multiply/divide iteration per cycle, WIDTH cycles
// FIX   | sign correction, HI/LO/div_zero write, done pulse
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 2 * WIDTH;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic             op_signed, op_is_div, is_div_q;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic [WIDTH:0]   mul_sum, div_rem_sh, div_trial;
  logic [AW-1:0]    mul_next, div_next;

  assign op_signed = op[0];
  assign op_is_div = op[1];
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign is_div_q  = (op_q == DIVU) || (op_q == DIV);

  mdu_negate #(.W(WIDTH)) u_neg_a (.neg_i(a_neg), .val_i(a), .val_o(a_mag));
  mdu_negate #(.W(WIDTH)) u_neg_b (.neg_i(b_neg), .val_i(b), .val_o(b_mag));

  mdu_negate #(.W(AW))    u_neg_prod (.neg_i(qneg_q), .val_i(acc_q),             .val_o(prod_fix));
  mdu_negate #(.W(WIDTH)) u_neg_quot (.neg_i(qneg_q), .val_i(acc_q[WIDTH-1:0]),  .val_o(quot_fix));
  mdu_negate #(.W(WIDTH)) u_neg_rem  (.neg_i(rneg_q), .val_i(acc_q[AW-1:WIDTH]), .val_o(rem_fix));

  // Multiply: acc = {partial product, remaining multiplier bits}; the sum keeps its carry.
  always_comb begin
    mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[AW-1:1]};
  end

  // Divide: acc = {partial remainder, dividend bits shifting into quotient bits}.
  always_comb begin
    div_rem_sh = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
    div_trial  = div_rem_sh - {1'b0, opnd_q};
    div_next   = div_trial[WIDTH] ? {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {div_trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    a_raw_d = a_raw_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          cnt_d   = CW'(WIDTH);
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          a_raw_d = a;
          if (op_is_div) begin
            opnd_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
          end
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (is_div_q) begin
          // A zero divisor ran through the normal datapath; its result is overridden here.
          if (opnd_q == '0) begin
            lo_d = '1;
            hi_d = a_raw_q;
            dz_d = 1'b1;
          end else begin
            lo_d = quot_fix;
            hi_d = rem_fix;
            dz_d = 1'b0;
          end
        end else begin
          hi_d = prod_fix[AW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
          dz_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      op_q    <= MULTU;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      a_raw_q <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      a_raw_q <= a_raw_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule
